// File: rtl/ok_result_arbiter_pkg.sv
// rtl/ok_result_arbiter_pkg.sv - shared state encoding, status layout and pointer helper
package ok_result_arbiter_pkg;

  // Width of requester indices and the round-robin pointer (covers up to 8 requesters)
  localparam int IDX_W = 3;

  // FSM encoding: IDLE has no unread result, HOLD waits for the host to consume it
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Status word field positions
  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_SRC_LSB   = 1;
  localparam int STATUS_SRC_W     = 3;
  localparam int STATUS_SEQ_LSB   = 8;
  localparam int STATUS_SEQ_W     = 8;

  // Pointer advance after a grant: one past the winner, wrapping at n
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) == n - 1) begin
      return '0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/ok_result_arbiter_rr_select.sv
// rtl/ok_result_arbiter_rr_select.sv - round-robin winner selection starting at ptr
module rr_select
  import ok_result_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] rotated;
  logic [3:0]   offset;
  logic [3:0]   sum;

  // Rotate requests so ptr lands at bit 0, take the lowest set bit, then map back to an absolute index
  always_comb begin
    rotated = N'({req, req} >> ptr);
    offset  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = 4'(k);
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= 4'(N)) begin
      sum = sum - 4'(N);
    end
    any    = |req;
    index  = any ? sum[IDX_W-1:0] : '0;
    winner = any ? (ONE << sum[IDX_W-1:0]) : '0;
  end

endmodule

// File: rtl/ok_result_arbiter.sv
// rtl/ok_result_arbiter.sv - round-robin arbiter feeding one host result register with toggle handshake
module ok_result_arbiter
  import ok_result_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           okClk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   grant,
  input  logic           host_ack,
  output logic [W-1:0]   result,
  output logic [31:0]    status
);

  logic [0:0]                state;
  logic [IDX_W-1:0]          ptr;
  logic                      ack_q;
  logic [STATUS_SRC_W-1:0]   src_id;
  logic [STATUS_SEQ_W-1:0]   seq;

  logic [N-1:0]     winner;
  logic [IDX_W-1:0] win_index;
  logic             any_req;
  logic [W-1:0]     win_data;
  logic             ack_toggle;

  rr_select #(.N(N)) u_rr_select (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .index  (win_index),
    .any    (any_req)
  );

  assign ack_toggle = (host_ack != ack_q);

  // Route the winning requester's data word toward the result register
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) begin
        win_data = req_data[i*W +: W];
      end
    end
  end

  // Capture/consume FSM: grant pulses for one cycle after a capture, host toggle frees the register
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      ack_q  <= 1'b0;
      grant  <= '0;
      result <= '0;
      src_id <= '0;
      seq    <= '0;
    end else begin
      ack_q <= host_ack;
      grant <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            result <= win_data;
            grant  <= winner;
            ptr    <= next_ptr(win_index, N);
            src_id <= win_index;
            seq    <= seq + 8'd1;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ack_toggle) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Assemble the host-visible status word; unused bits stay zero
  always_comb begin
    status = '0;
    status[STATUS_VALID_BIT]                  = (state == ST_HOLD);
    status[STATUS_SRC_LSB +: STATUS_SRC_W]    = src_id;
    status[STATUS_SEQ_LSB +: STATUS_SEQ_W]    = seq;
  end

endmodule

// File: tb/tb_ok_result_arbiter.sv
// tb/tb_ok_result_arbiter.sv - scoreboard bench for ok_result_arbiter
module tb_ok_result_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           okClk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic           host_ack;
  logic [W-1:0]   result;
  logic [31:0]    status;

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] d;
    logic [31:0]  st;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   m_ptr   = 0;
  logic [7:0] m_seq = 8'd0;
  logic [W-1:0] words [N];

  ok_result_arbiter #(.N(N), .W(W)) dut (
    .okClk    (okClk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .host_ack (host_ack),
    .result   (result),
    .status   (status)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every grant pulse must match the oldest expected capture
  always @(negedge okClk) begin
    if (rst_n && grant !== '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_grant: got grant=%b, required no grant", grant);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (grant !== e.g) begin
          errors++;
          $display("FAIL %s grant: got %b required %b", e.name, grant, e.g);
        end
        vectors++;
        if (result !== e.d) begin
          errors++;
          $display("FAIL %s result: got %h required %h", e.name, result, e.d);
        end
        vectors++;
        if (status !== e.st) begin
          errors++;
          $display("FAIL %s status: got %h required %h", e.name, status, e.st);
        end
      end
    end
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  task automatic load_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
  endtask

  task automatic push_expect(input logic [N-1:0] r, input string name);
    exp_t e;
    int   w;
    w = pick(r, m_ptr);
    m_seq = m_seq + 8'd1;
    e.g    = 4'(1 << w);
    e.d    = words[w];
    e.st   = {16'h0, m_seq, 4'h0, 3'(w), 1'b1};
    e.name = name;
    exp_q.push_back(e);
    m_ptr = (w + 1) % N;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4) begin
      @(negedge okClk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s timeout: got %0d pending grants, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #3;
    @(negedge okClk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_seq = 8'd0;
    @(negedge okClk);
    #1;
  endtask

  task automatic capture(input logic [N-1:0] r, input string name);
    for (int i = 0; i < N; i++) words[i] = $urandom;
    load_data();
    push_expect(r, name);
    req = r;
    wait_drain(name);
    req = '0;
  endtask

  task automatic ack_toggle(input string name);
    host_ack = ~host_ack;
    @(posedge okClk);
    #1;
    vectors++;
    if (status[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got valid=%b required 0", name, status[0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (grant !== '0 || result !== '0 || status !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got grant=%b result=%h status=%h required all 0", grant, result, status);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    words[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < N; i++) words[i] = $urandom;
    load_data();
    push_expect(4'b0001, "single");
    req = 4'b0001;
    wait_drain("single");
    req = '0;
    vectors++;
    if (result !== 32'hDEADBEEF || status !== 32'h0000_0101) begin
      errors++;
      $display("FAIL single_hold: got result=%h status=%h required deadbeef 00000101", result, status);
    end
    ack_toggle("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      capture(4'b1111, "round_robin");
      ack_toggle("round_robin");
    end
    vectors++;
    if (status[15:8] !== 8'd5) begin
      errors++;
      $display("FAIL rr_seq: got %0d required 5", status[15:8]);
    end
  endtask

  task automatic test_req_during_hold();
    do_reset();
    capture(4'b0001, "hold_first");
    for (int i = 0; i < N; i++) words[i] = $urandom;
    load_data();
    req = 4'b0100;
    repeat (3) @(negedge okClk);
    #1;
    vectors++;
    if (status[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid: got %b required 1", status[0]);
    end
    push_expect(4'b0100, "hold_second");
    host_ack = ~host_ack;
    wait_drain("hold_second");
    req = '0;
    ack_toggle("hold_second");
  endtask

  task automatic test_idle_toggle();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      host_ack = ~host_ack;
      @(posedge okClk);
      #1;
      vectors++;
      if (status !== 32'h0 || grant !== '0) begin
        errors++;
        $display("FAIL idle_toggle: got status=%h grant=%b required 0", status, grant);
      end
    end
    capture(4'b0010, "after_idle_toggle");
    ack_toggle("after_idle_toggle");
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int c = 0; c < 256; c++) begin
      capture(4'(1 << $urandom_range(0, N - 1)) | 4'($urandom_range(0, 15)), "seq_wrap");
      ack_toggle("seq_wrap");
    end
    vectors++;
    if (status[15:8] !== 8'h00) begin
      errors++;
      $display("FAIL seq_wrap_final: got %h required 00", status[15:8]);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    capture(4'b0100, "pre_reset");
    rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== '0 || status !== 32'h0 || grant !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold: got result=%h status=%h grant=%b required 0", result, status, grant);
    end
    do_reset();
    capture(4'b1010, "ptr_after_reset");
    ack_toggle("ptr_after_reset");
  endtask

  initial begin
    req      = '0;
    req_data = '0;
    host_ack = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_req_during_hold();
    host_ack = 1'b1;
    test_idle_toggle();
    test_seq_wrap();
    test_reset_mid_hold();
    repeat (3) @(negedge okClk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
